lsm: RTL and testbench
======================

Name: lsm

Overview:
- Load/store master. Takes one memory request per transaction from the execute stage and turns it into a single pipelined Wishbone B4 cycle.
- Drives the data-side slave port of the external memory arbiter.
- Handles byte/halfword lane alignment, load sign/zero extension, misalignment detection and a bus-timeout watchdog.
- Returns one response per accepted request.

Parameters:
TIMEOUT_CYCLES, 255, maximum number of cycles from stb assertion to ack before the cycle is aborted; legal range 1..65535.

Ports:
clk_i  in  1  clock; all logic is on the rising edge
rst_i  in  1  synchronous, active-low reset (rst_i==0 resets on the clock edge)
req_valid_i  in  1  execute stage presents a request
req_ready_o  out  1  lsm can accept a request this cycle
req_we_i  in  1  1=store, 0=load
req_adr_i  in  32  byte address
req_dat_i  in  32  store data, right-aligned
req_size_i  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned_i  in  1  load: 1=zero-extend, 0=sign-extend
rsp_valid_o  out  1  one-cycle response pulse
rsp_dat_o  out  32  extended load data; 0 for stores and errors
rsp_err_o  out  2  0=none, 1=misaligned, 2=timeout, 3=illegal size
wb_adr_o  out  32  word address {adr[31:2],2'b00}
wb_dat_i  in  32  read data
wb_dat_o  out  32  lane-replicated write data
wb_we_o  out  1  write enable
wb_sel_o  out  4  byte lanes
wb_stb_o  out  1  strobe
wb_ack_i  in  1  acknowledge
wb_cyc_o  out  1  cycle
wb_stall_i  in  1  stall

Behaviour:
- Reset values:
  - req_ready_o=0 during reset, 1 from the first non-reset cycle.
  - rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0.
  - wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0.
  - State IDLE; timeout counter 0.
- States:
  - IDLE: req_ready_o=1. Acceptance is req_valid_i && req_ready_o. All request fields are registered on acceptance.
    - Request passes checks -> REQUEST.
    - Otherwise -> RESPOND with rsp_err_o set. No bus activity.
  - Check priority: illegal size, then misaligned (half with adr[0]=1; word with adr[1:0]!=0).
  - REQUEST: cyc=1, stb=1; adr/sel/dat/we held stable.
    - wb_stall_i=0 and wb_ack_i=0 -> WAIT_ACK.
    - wb_stall_i=0 and wb_ack_i=1 -> RESPOND.
    - wb_stall_i=1 -> stay.
  - WAIT_ACK: cyc=1, stb=0. wb_ack_i=1 -> RESPOND.
  - RESPOND: cyc=0, stb=0, rsp_valid_o=1 for exactly one cycle, req_ready_o=0 -> IDLE.
- Lane rules (o = adr[1:0]):
  - sel: byte 4'b0001<<o; half 4'b0011<<{o[1],0}; word 4'b1111.
  - wb_dat_o: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
  - Load data: the lane is extracted from wb_dat_i captured on the ack cycle, then sign- or zero-extended to 32 bits.
- Latency (accept at cycle T):
  - stb rises at T+1.
  - Earliest ack is at T+1, giving rsp_valid_o at T+2.
  - Error responses (no bus cycle) appear at T+1.
  - Next acceptance is possible one cycle after RESPOND.
- Timeout:
  - Counter clears on entry to REQUEST and increments every cycle in REQUEST or WAIT_ACK.
  - Reaching TIMEOUT_CYCLES without ack -> drop cyc/stb on the next edge -> RESPOND with rsp_err_o=2, rsp_dat_o=0.
  - Ack and timeout in the same cycle: ack wins.
- Boundary conditions:
  - wb_ack_i in IDLE or RESPOND is ignored.
  - wb_stall_i is ignored outside REQUEST.
  - req_valid_i while not ready has no effect; the requester must hold it.
  - Reset mid-transaction: cyc/stb low after the reset edge, state IDLE, response discarded, no rsp_valid_o pulse.
  - Stores: rsp_dat_o=0, rsp_err_o=0 on success.

Decomposition:
- ecap5_dproc_pkg adds:
  - lsm_size_t enum (BYTE, HALF, WORD, ILLEGAL).
  - lsm_err_t enum (NONE, MISALIGNED, TIMEOUT, ILLEGAL_SIZE).
  - LSM_TIMEOUT_DEFAULT constant.
- The FSM state typedef stays local to lsm.
- One combinational sub-module, lsm_align: computes sel, write-data replication, misalignment/illegal flags, and load extraction/extension. It can be unit-tested exhaustively.

Test Plan:
- Word load, adr=0x1000, stall=0, ack one cycle after stb, wb_dat_i=0xDEADBEEF -> wb_adr_o=0x1000, wb_sel_o=4'hF, single rsp_valid_o with rsp_dat_o=0xDEADBEEF, rsp_err_o=0.
- Signed byte load, adr=0x1003, wb_dat_i=0x80FF0000 -> wb_sel_o=4'b1000, rsp_dat_o=0xFFFFFF80. Same access with req_unsigned_i=1 -> rsp_dat_o=0x00000080.
- Half store, adr=0x2002, req_dat_i=0x1234ABCD, stall high 3 cycles -> stb held 4 cycles with stable wb_dat_o=0xABCDABCD and wb_sel_o=4'b1100; rsp_valid_o after ack with rsp_dat_o=0.
- Word load at adr=0x3001; separately req_size_i=3 -> no wb_cyc_o; rsp_valid_o at T+1 with rsp_err_o=1 and 3 respectively.
- TIMEOUT_CYCLES=4, never ack -> cyc drops after 4 cycles; rsp_err_o=2. Ack arriving on the 4th cycle -> normal response.
- Reset (rst_i=0) asserted while in WAIT_ACK -> cyc=0 next edge, no rsp_valid_o; a later ack is ignored; the next request completes normally.

Source files
------------

// File: rtl/ecap5_dproc_pkg.sv
// Shared types for the data-side processor blocks: access sizes, load/store
// error codes and the default bus watchdog limit.
package ecap5_dproc_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE    = 2'd0,
      SZ_HALF    = 2'd1,
      SZ_WORD    = 2'd2,
      SZ_ILLEGAL = 2'd3
   } lsm_size_t;

   typedef enum logic [1:0] {
      ERR_NONE         = 2'd0,
      ERR_MISALIGNED   = 2'd1,
      ERR_TIMEOUT      = 2'd2,
      ERR_ILLEGAL_SIZE = 2'd3
   } lsm_err_t;

   localparam int unsigned LSM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsm_align.sv
// Byte-lane steering for the load/store master: lane selects, store data
// replication, alignment checks and load extraction with sign/zero extension.
module lsm_align
   import ecap5_dproc_pkg::*;
(
   input  lsm_size_t   size_i,
   input  logic [1:0]  off_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdat_i,
   input  logic [31:0] rdat_i,
   output logic [3:0]  sel_o,
   output logic [31:0] wdat_o,
   output logic        misaligned_o,
   output logic        illegal_o,
   output logic [31:0] ldat_o
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic        ext_byte;
   logic        ext_half;

   // NOTE: every signal gets a default before the case, so no path can infer a latch.
   always_comb begin
      rd_byte      = rdat_i[7:0];
      rd_half      = off_i[1] ? rdat_i[31:16] : rdat_i[15:0];
      sel_o        = 4'b0000;
      wdat_o       = wdat_i;
      misaligned_o = 1'b0;
      illegal_o    = 1'b0;
      ldat_o       = rdat_i;

      case (off_i)
         2'd0:    rd_byte = rdat_i[7:0];
         2'd1:    rd_byte = rdat_i[15:8];
         2'd2:    rd_byte = rdat_i[23:16];
         default: rd_byte = rdat_i[31:24];
      endcase
      ext_byte = ~unsigned_i & rd_byte[7];
      ext_half = ~unsigned_i & rd_half[15];

      case (size_i)
         SZ_BYTE: begin
            sel_o  = 4'b0001 << off_i;
            wdat_o = {4{wdat_i[7:0]}};
            ldat_o = {{24{ext_byte}}, rd_byte};
         end
         SZ_HALF: begin
            sel_o        = 4'b0011 << {off_i[1], 1'b0};
            wdat_o       = {2{wdat_i[15:0]}};
            misaligned_o = off_i[0];
            ldat_o       = {{16{ext_half}}, rd_half};
         end
         SZ_WORD: begin
            sel_o        = 4'b1111;
            misaligned_o = |off_i;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/lsm.sv
// Load/store master: turns one execute-stage memory request into a single
// pipelined Wishbone B4 cycle and returns one response, with a bus watchdog.
module lsm
   import ecap5_dproc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = LSM_TIMEOUT_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_adr_i,
   input  logic [31:0] req_dat_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_dat_o,
   output logic [1:0]  rsp_err_o,
   output logic [31:0] wb_adr_o,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   output logic        wb_cyc_o,
   input  logic        wb_stall_i
);

   typedef enum logic [1:0] {IDLE, REQUEST, WAIT_ACK, RESPOND} state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        ready_q, ready_d;
   logic [15:0] cnt_q, cnt_d;
   logic [29:0] adr_q, adr_d;
   logic [1:0]  off_q, off_d;
   lsm_size_t   size_q, size_d;
   logic        uns_q, uns_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] wdat_q, wdat_d;
   logic [31:0] rsp_dat_q, rsp_dat_d;
   lsm_err_t    rsp_err_q, rsp_err_d;

   lsm_size_t   al_size;
   logic [1:0]  al_off;
   logic [3:0]  al_sel;
   logic [31:0] al_wdat;
   logic        al_misaligned;
   logic        al_illegal;
   logic [31:0] al_ldat;
   logic        timeout_hit;

   // In IDLE the aligner checks the incoming request; afterwards it decodes the held one.
   assign al_size = (state_q == IDLE) ? lsm_size_t'(req_size_i) : size_q;
   assign al_off  = (state_q == IDLE) ? req_adr_i[1:0] : off_q;

   lsm_align u_align (
      .size_i       (al_size),
      .off_i        (al_off),
      .unsigned_i   (uns_q),
      .wdat_i       (req_dat_i),
      .rdat_i       (wb_dat_i),
      .sel_o        (al_sel),
      .wdat_o       (al_wdat),
      .misaligned_o (al_misaligned),
      .illegal_o    (al_illegal),
      .ldat_o       (al_ldat)
   );

   assign timeout_hit = (cnt_q == TIMEOUT_LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      adr_d     = adr_q;
      off_d     = off_q;
      size_d    = size_q;
      uns_d     = uns_q;
      we_d      = we_q;
      sel_d     = sel_q;
      wdat_d    = wdat_q;
      rsp_dat_d = '0;
      rsp_err_d = ERR_NONE;

      case (state_q)
         IDLE: begin
            if (req_valid_i && ready_q) begin
               adr_d  = req_adr_i[31:2];
               off_d  = req_adr_i[1:0];
               size_d = lsm_size_t'(req_size_i);
               uns_d  = req_unsigned_i;
               we_d   = req_we_i;
               sel_d  = al_sel;
               wdat_d = al_wdat;
               if (al_illegal) begin
                  state_d   = RESPOND;
                  rsp_err_d = ERR_ILLEGAL_SIZE;
               end else if (al_misaligned) begin
                  state_d   = RESPOND;
                  rsp_err_d = ERR_MISALIGNED;
               end else begin
                  state_d = REQUEST;
                  cnt_d   = '0;
               end
            end
         end
         REQUEST: begin
            cnt_d = cnt_q + 16'd1;
            if (!wb_stall_i && wb_ack_i) begin
               state_d   = RESPOND;
               rsp_dat_d = we_q ? '0 : al_ldat;
            end else if (timeout_hit) begin
               state_d   = RESPOND;
               rsp_err_d = ERR_TIMEOUT;
            end else if (!wb_stall_i) begin
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            cnt_d = cnt_q + 16'd1;
            // An ack in the watchdog's last cycle still completes the access.
            if (wb_ack_i) begin
               state_d   = RESPOND;
               rsp_dat_d = we_q ? '0 : al_ldat;
            end else if (timeout_hit) begin
               state_d   = RESPOND;
               rsp_err_d = ERR_TIMEOUT;
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         cnt_q     <= '0;
         adr_q     <= '0;
         off_q     <= '0;
         size_q    <= SZ_BYTE;
         uns_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         wdat_q    <= '0;
         rsp_dat_q <= '0;
         rsp_err_q <= ERR_NONE;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         cnt_q     <= cnt_d;
         adr_q     <= adr_d;
         off_q     <= off_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         wdat_q    <= wdat_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = (state_q == RESPOND);
   assign rsp_dat_o   = rsp_dat_q;
   assign rsp_err_o   = rsp_err_q;
   assign wb_cyc_o    = (state_q == REQUEST) || (state_q == WAIT_ACK);
   assign wb_stb_o    = (state_q == REQUEST);
   assign wb_adr_o    = {adr_q, 2'b00};
   assign wb_dat_o    = wdat_q;
   assign wb_we_o     = we_q;
   assign wb_sel_o    = sel_q;

endmodule

// File: tb/tb_lsm.sv
// Bench for lsm: directed accesses plus random traffic against a
// transaction-level model of lanes, errors, latency and the watchdog.
module tb_lsm;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [31:0] req_adr_i;
   logic [31:0] req_dat_i;
   logic [1:0]  req_size_i;
   logic        req_unsigned_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_dat_o;
   logic [1:0]  rsp_err_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic        wb_stb_o;
   logic        wb_ack_i;
   logic        wb_cyc_o;
   logic        wb_stall_i;

   always #5 clk_i = ~clk_i;

   lsm #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_adr_i      (req_adr_i),
      .req_dat_i      (req_dat_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_dat_o      (rsp_dat_o),
      .rsp_err_o      (rsp_err_o),
      .wb_adr_o       (wb_adr_o),
      .wb_dat_i       (wb_dat_i),
      .wb_dat_o       (wb_dat_o),
      .wb_we_o        (wb_we_o),
      .wb_sel_o       (wb_sel_o),
      .wb_stb_o       (wb_stb_o),
      .wb_ack_i       (wb_ack_i),
      .wb_cyc_o       (wb_cyc_o),
      .wb_stall_i     (wb_stall_i)
   );

   int n_vec = 0;
   int n_err = 0;

   // Expected outputs for the current cycle, set by the driver after each rising edge.
   bit          chk_en  = 1'b0;
   bit          e_reset = 1'b0;
   bit          e_ready, e_cyc, e_stb, e_rsp, e_we;
   logic [31:0] e_adr, e_wdat, e_rdat;
   logic [3:0]  e_sel;
   logic [1:0]  e_rerr;

   // Observations used by the hand-computed directed expectations.
   int          stb_cnt, rsp_cnt;
   logic [31:0] last_rsp_dat, last_adr, last_wdat;
   logic [1:0]  last_rsp_err;
   logic [3:0]  last_sel;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int m_bytes(input logic [1:0] size);
      return 1 << int'(size);
   endfunction

   function automatic logic [1:0] m_err(input logic [1:0] size, input logic [1:0] off);
      if (size == 2'd3) return 2'd3;
      return ((int'(off) % m_bytes(size)) != 0) ? 2'd1 : 2'd0;
   endfunction

   function automatic int m_base(input logic [1:0] size, input logic [1:0] off);
      return int'(off) - (int'(off) % m_bytes(size));
   endfunction

   function automatic logic [3:0] m_sel(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] s;
      int b, nb;
      b  = m_base(size, off);
      nb = m_bytes(size);
      for (int i = 0; i < 4; i++) s[i] = (i >= b) && (i < b + nb);
      return s;
   endfunction

   function automatic logic [31:0] m_wdat(input logic [1:0] size, input logic [31:0] d);
      logic [31:0] w;
      int nb;
      nb = m_bytes(size);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] rdat, input logic [1:0] size,
                                          input logic [1:0] off, input logic uns);
      logic [31:0] v, mask;
      int nb;
      nb = m_bytes(size);
      v  = rdat >> (8 * m_base(size, off));
      if (nb < 4) begin
         mask = (32'd1 << (8 * nb)) - 32'd1;
         v    = v & mask;
         if (!uns && v[8*nb-1]) v = v | ~mask;
      end
      return v;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk_i) begin
      if (chk_en) begin
         if (wb_stb_o) begin
            stb_cnt++;
            last_sel  = wb_sel_o;
            last_adr  = wb_adr_o;
            last_wdat = wb_dat_o;
         end
         if (rsp_valid_o) begin
            rsp_cnt++;
            last_rsp_dat = rsp_dat_o;
            last_rsp_err = rsp_err_o;
         end
         if (e_reset) begin
            check("rst_ready",   32'(req_ready_o), 32'd0);
            check("rst_cyc",     32'(wb_cyc_o),    32'd0);
            check("rst_stb",     32'(wb_stb_o),    32'd0);
            check("rst_we",      32'(wb_we_o),     32'd0);
            check("rst_sel",     32'(wb_sel_o),    32'd0);
            check("rst_adr",     wb_adr_o,         32'd0);
            check("rst_wdat",    wb_dat_o,         32'd0);
            check("rst_rsp_vld", 32'(rsp_valid_o), 32'd0);
            check("rst_rsp_dat", rsp_dat_o,        32'd0);
            check("rst_rsp_err", 32'(rsp_err_o),   32'd0);
         end else begin
            check("ready",     32'(req_ready_o), 32'(e_ready));
            check("cyc",       32'(wb_cyc_o),    32'(e_cyc));
            check("stb",       32'(wb_stb_o),    32'(e_stb));
            check("rsp_valid", 32'(rsp_valid_o), 32'(e_rsp));
            if (e_cyc) begin
               check("wb_adr", wb_adr_o,      e_adr);
               check("wb_sel", 32'(wb_sel_o), 32'(e_sel));
               check("wb_dat", wb_dat_o,      e_wdat);
               check("wb_we",  32'(wb_we_o),  32'(e_we));
            end
            if (e_rsp) begin
               check("rsp_dat", rsp_dat_o,       e_rdat);
               check("rsp_err", 32'(rsp_err_o),  32'(e_rerr));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic junk_req();
      req_valid_i    = 1'($urandom);
      req_we_i       = 1'($urandom);
      req_adr_i      = $urandom;
      req_dat_i      = $urandom;
      req_size_i     = 2'($urandom);
      req_unsigned_i = 1'($urandom);
   endtask

   task automatic junk_bus();
      wb_ack_i   = 1'($urandom);
      wb_stall_i = 1'($urandom);
      wb_dat_i   = $urandom;
   endtask

   task automatic set_idle();
      req_valid_i = 1'b0;
      junk_bus();
      e_ready = 1'b1;
      e_cyc   = 1'b0;
      e_stb   = 1'b0;
      e_rsp   = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         set_idle();
         next_cycle();
      end
      set_idle();
   endtask

   task automatic do_reset(input int n);
      rst_i = 1'b0;
      for (int i = 0; i < n; i++) begin
         junk_req();
         junk_bus();
         next_cycle();
         chk_en  = 1'b1;
         e_reset = 1'b1;
      end
      rst_i = 1'b1;
      junk_req();
      junk_bus();
      next_cycle();
      e_reset = 1'b0;
      set_idle();
   endtask

   task automatic clear_obs();
      stb_cnt      = 0;
      rsp_cnt      = 0;
      last_rsp_dat = 32'hBAD0BAD0;
      last_rsp_err = 2'bxx;
      last_sel     = 4'bxxxx;
      last_adr     = 32'hBAD0BAD0;
      last_wdat    = 32'hBAD0BAD0;
   endtask

   // Present one request in the current (idle) cycle and play the slave side:
   // stall for stall_n cycles, then ack dly cycles after stb is taken.
   // rst_at > 0 pulls reset in that cycle of the transaction instead of finishing it.
   task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [1:0] size, input logic uns, input int stall_n,
                         input int dly, input logic [31:0] rdat, input int rst_at);
      logic [1:0] err;
      bit tmo;
      int ack_idx, rsp_k, cyc_last, stb_last;

      err     = m_err(size, adr[1:0]);
      ack_idx = stall_n + 1 + dly;
      tmo     = (err == 2'd0) && (ack_idx > TO);
      if (err != 2'd0) begin
         rsp_k = 1; cyc_last = 0; stb_last = 0;
      end else if (tmo) begin
         rsp_k = TO + 1; cyc_last = TO; stb_last = (stall_n + 1 < TO) ? stall_n + 1 : TO;
      end else begin
         rsp_k = ack_idx + 1; cyc_last = ack_idx; stb_last = stall_n + 1;
      end
      e_adr  = {adr[31:2], 2'b00};
      e_we   = we;
      e_sel  = m_sel(size, adr[1:0]);
      e_wdat = m_wdat(size, dat);
      e_rdat = (err != 2'd0 || tmo || we) ? 32'd0 : m_load(rdat, size, adr[1:0], uns);
      e_rerr = tmo ? 2'd2 : err;

      set_idle();
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_adr_i      = adr;
      req_dat_i      = dat;
      req_size_i     = size;
      req_unsigned_i = uns;
      next_cycle();

      for (int k = 1; k <= rsp_k; k++) begin
         junk_req();
         e_ready = 1'b0;
         e_cyc   = (k <= cyc_last);
         e_stb   = (k <= stb_last);
         e_rsp   = (k == rsp_k);
         if (k <= cyc_last) begin
            wb_stall_i = (k <= stall_n)     ? 1'b1 :
                         (k == stall_n + 1) ? 1'b0 : 1'($urandom);
            wb_ack_i   = (k > stall_n) && (k == ack_idx);
            wb_dat_i   = (k == ack_idx) ? rdat : $urandom;
         end else begin
            junk_bus();
         end
         if (k == rst_at) begin
            do_reset(2);
            return;
         end
         next_cycle();
      end
      set_idle();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst_i = 1'b0;
      junk_req();
      junk_bus();
      e_ready = 1'b0; e_cyc = 1'b0; e_stb = 1'b0; e_rsp = 1'b0; e_we = 1'b0;
      e_adr = '0; e_wdat = '0; e_rdat = '0; e_sel = '0; e_rerr = '0;
      clear_obs();
      do_reset(3);

      // word load, ack one cycle after stb
      clear_obs();
      do_txn(1'b0, 32'h0000_1000, 32'h0, 2'd2, 1'b0, 0, 1, 32'hDEAD_BEEF, 0);
      check("tp_word_adr", last_adr,           32'h0000_1000);
      check("tp_word_sel", 32'(last_sel),      32'h0000_000F);
      check("tp_word_rsp", 32'(rsp_cnt),       32'd1);
      check("tp_word_dat", last_rsp_dat,       32'hDEAD_BEEF);
      check("tp_word_err", 32'(last_rsp_err),  32'd0);

      // signed and unsigned byte loads from the top lane
      clear_obs();
      do_txn(1'b0, 32'h0000_1003, 32'h0, 2'd0, 1'b0, 0, 1, 32'h80FF_0000, 0);
      check("tp_sbyte_sel", 32'(last_sel), 32'h0000_0008);
      check("tp_sbyte_dat", last_rsp_dat,  32'hFFFF_FF80);
      clear_obs();
      do_txn(1'b0, 32'h0000_1003, 32'h0, 2'd0, 1'b1, 0, 1, 32'h80FF_0000, 0);
      check("tp_ubyte_dat", last_rsp_dat,  32'h0000_0080);

      // half store held through three stall cycles
      clear_obs();
      do_txn(1'b1, 32'h0000_2002, 32'h1234_ABCD, 2'd1, 1'b0, 3, 0, 32'h5555_5555, 0);
      check("tp_hst_stb_cycles", 32'(stb_cnt),  32'd4);
      check("tp_hst_wdat",       last_wdat,     32'hABCD_ABCD);
      check("tp_hst_sel",        32'(last_sel), 32'h0000_000C);
      check("tp_hst_dat",        last_rsp_dat,  32'd0);

      // misaligned word and illegal size: no bus cycle
      clear_obs();
      do_txn(1'b0, 32'h0000_3001, 32'h0, 2'd2, 1'b0, 0, 0, 32'h0, 0);
      check("tp_misal_stb", 32'(stb_cnt),      32'd0);
      check("tp_misal_err", 32'(last_rsp_err), 32'd1);
      clear_obs();
      do_txn(1'b0, 32'h0000_3000, 32'h0, 2'd3, 1'b0, 0, 0, 32'h0, 0);
      check("tp_illegal_err", 32'(last_rsp_err), 32'd3);

      // watchdog expiry, then an ack in the watchdog's last cycle
      clear_obs();
      do_txn(1'b0, 32'h0000_4000, 32'h0, 2'd2, 1'b0, 0, 20, 32'h1111_2222, 0);
      check("tp_tmo_err", 32'(last_rsp_err), 32'd2);
      check("tp_tmo_dat", last_rsp_dat,      32'd0);
      clear_obs();
      do_txn(1'b0, 32'h0000_4000, 32'h0, 2'd2, 1'b0, 0, TO - 1, 32'h1111_2222, 0);
      check("tp_lastack_err", 32'(last_rsp_err), 32'd0);
      check("tp_lastack_dat", last_rsp_dat,      32'h1111_2222);

      // reset while waiting for ack; later acks are ignored
      clear_obs();
      do_txn(1'b0, 32'h0000_5000, 32'h0, 2'd2, 1'b0, 0, 20, 32'h0, 2);
      for (int i = 0; i < 4; i++) begin
         set_idle();
         wb_ack_i = 1'b1;
         next_cycle();
      end
      set_idle();
      check("tp_rst_no_rsp", 32'(rsp_cnt), 32'd0);
      clear_obs();
      do_txn(1'b0, 32'h0000_5004, 32'h0, 2'd1, 1'b1, 1, 0, 32'hC0DE_8001, 0);
      check("tp_after_rst_dat", last_rsp_dat, 32'h0000_8001);

      // random traffic
      for (int n = 0; n < 250; n++) begin
         logic [31:0] adr;
         logic [1:0]  size;
         int          stall_n;
         size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         adr  = $urandom;
         if ($urandom_range(0, 2) != 0 && size != 2'd3)
            adr[1:0] = adr[1:0] & ~2'(m_bytes(size) - 1);
         stall_n = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, 2);
         do_txn(1'($urandom), adr, $urandom, size, 1'($urandom),
                stall_n, $urandom_range(0, 4), $urandom, 0);
         idle($urandom_range(0, 2));
      end

      idle(2);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
